// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default address width and a saturating-add helper.
package data_mem_responder_pkg;

  localparam int DMR_ADDR_W = 17;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUSY = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_DONE = 2'd3
  } dmr_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == STALL_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_mem_responder.sv
// MEM-stage responder: posted stores, blocking loads, stall accounting.
// Ports: clk/rst; pipeline memread/memwrite/addr/wdata/alu_ready in,
//   data_ready/load data out; ext_* backing-memory request/ack;
//   err_flag (sticky read+write clash), stall_cycles (saturating).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = DMR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_memory_mem,
  input  logic              alu_ready,
  output logic              data_ready_mem,
  output logic [31:0]       data_from_memory_mem,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [31:0]       ext_wdata,
  input  logic              ext_ack,
  input  logic [31:0]       ext_rdata,
  output logic              err_flag,
  output logic [31:0]       stall_cycles
);

  dmr_state_e        state;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] word_addr;
  logic              is_ld;
  logic              is_st;
  logic              unused_addr_bits;

  // A read+write clash is handled as a load.
  assign is_ld = memread_mem;
  assign is_st = memwrite_mem & ~memread_mem;

  assign word_addr = alu_result_mem[ADDR_W+1:2];

  assign unused_addr_bits =
    ^{alu_result_mem[31:ADDR_W+2],
      alu_result_mem[1:0]};

  assign data_from_memory_mem = rdata_q;

  always_comb begin
    data_ready_mem = 1'b1;
    unique case (state)
      ST_IDLE: begin
        data_ready_mem = ~is_ld;
      end
      ST_WR_BUSY: begin
        // Loads wait for the posted store;
        // a new store slips in only on ack.
        if (is_ld) begin
          data_ready_mem = 1'b0;
        end else if (is_st) begin
          data_ready_mem = ext_ack;
        end
      end
      ST_RD_WAIT: begin
        data_ready_mem = 1'b0;
      end
      ST_RD_DONE: begin
        data_ready_mem = 1'b1;
      end
      default: begin
        data_ready_mem = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ext_req      <= 1'b0;
      ext_we       <= 1'b0;
      ext_addr     <= '0;
      ext_wdata    <= '0;
      rdata_q      <= '0;
      err_flag     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (memread_mem && memwrite_mem) begin
        err_flag <= 1'b1;
      end
      if (!data_ready_mem) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      unique case (state)
        ST_IDLE: begin
          if (is_ld) begin
            ext_req  <= 1'b1;
            ext_we   <= 1'b0;
            ext_addr <= word_addr;
            state    <= ST_RD_WAIT;
          end else if (is_st && alu_ready) begin
            ext_req   <= 1'b1;
            ext_we    <= 1'b1;
            ext_addr  <= word_addr;
            ext_wdata <= write_data_memory_mem;
            state     <= ST_WR_BUSY;
          end
        end
        ST_WR_BUSY: begin
          if (ext_ack) begin
            if (is_st && alu_ready) begin
              // Chain the next store with no idle gap.
              ext_addr  <= word_addr;
              ext_wdata <= write_data_memory_mem;
            end else begin
              ext_req <= 1'b0;
              ext_we  <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_RD_WAIT: begin
          if (ext_ack) begin
            rdata_q <= ext_rdata;
            ext_req <= 1'b0;
            state   <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          if (alu_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
